// File: rtl/uart_tx.sv
// 8N1/8E1 UART transmitter with PSCALER x DIV bit timing.
// Accepts one byte per valid/ready handshake and shifts it out LSB first.
module uart_tx #(
    parameter int PSCALER = 625,
    parameter int DIV     = 10
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       parity_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PSCALER - 1);
    localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_en_q, par_en_d;
    logic            par_bit_q, par_bit_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            presc_wrap;
    logic            bit_end;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        presc_wrap = (presc_q == PMAX);
        bit_end    = presc_wrap && (tick_q == TMAX);

        // Counters only run inside a frame; IDLE and recovery force them to 0.
        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        if (bit_end) begin
            tick_d = '0;
        end else if (presc_wrap) begin
            tick_d = tick_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                presc_d = '0;
                tick_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (valid_i && ready_q) begin
                    state_d   = START;
                    shift_d   = data_i;
                    par_en_d  = parity_i;
                    par_bit_d = ^data_i;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                tick_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign tx_o    = tx_q;

endmodule
